// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the down-counting timer
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_down_timer.sv
// rtl/counter_down_timer.sv - loadable down-counting timer with borrow-out, one-shot or periodic
module counter_down_timer
  import counter_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] cnt,
  output logic          bo,
  output logic          busy,
  output logic          done
);

  timer_state_t  state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          mode_q, mode_d;
  logic          at_zero;

  assign at_zero = (cnt_q == '0);

  // State, count and the reload/mode shadows captured at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
    end
  end

  // Next state: start beats stop, stop beats counting; the count never decrements past zero
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    if (start) begin
      state_d  = RUN;
      cnt_d    = load_val;
      shadow_d = load_val;
      mode_d   = mode;
    end else if (stop) begin
      state_d = IDLE;
    end else if (state_q == RUN && en) begin
      if (!at_zero) begin
        cnt_d = cnt_q - DW'(1);
      end else if (mode_q == MODE_PERIODIC) begin
        cnt_d = shadow_q;
      end else begin
        state_d = DONE;
      end
    end
  end

  assign cnt  = cnt_q;
  assign bo   = en && (state_q == RUN) && at_zero;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_counter_down_timer.sv
// tb/tb_counter_down_timer.sv - table-driven scoreboard bench for counter_down_timer
module tb_counter_down_timer;

  localparam int DW = 8;

  typedef struct {
    string      name;
    logic       start;
    logic       stop;
    logic       mode;
    logic       en;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic       bo;
    logic       busy;
    logic       done;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          start;
  logic          stop;
  logic          mode;
  logic [DW-1:0] load_val;
  logic [DW-1:0] cnt;
  logic          bo;
  logic          busy;
  logic          done;

  vec_t table_q[$];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  counter_down_timer #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .load_val (load_val),
    .cnt      (cnt),
    .bo       (bo),
    .busy     (busy),
    .done     (done)
  );

  function automatic vec_t mk(string name, bit s, bit p, bit m, bit e, int lv,
                              int c, bit b, bit bz, bit d);
    vec_t v;
    v.name  = name;
    v.start = s;
    v.stop  = p;
    v.mode  = m;
    v.en    = e;
    v.lv    = lv[7:0];
    v.cnt   = c[7:0];
    v.bo    = b;
    v.busy  = bz;
    v.done  = d;
    return v;
  endfunction

  task automatic compare_next();
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (cnt !== e.cnt || bo !== e.bo || busy !== e.busy || done !== e.done) begin
        errors++;
        $display("FAIL %s: got cnt=%0d bo=%b busy=%b done=%b, want cnt=%0d bo=%b busy=%b done=%b",
                 e.name, cnt, bo, busy, done, e.cnt, e.bo, e.busy, e.done);
      end
    end
  endtask

  task automatic apply(vec_t v);
    @(posedge clk);
    #1;
    start    = v.start;
    stop     = v.stop;
    mode     = v.mode;
    en       = v.en;
    load_val = v.lv;
    sb_q.push_back(v);
    @(negedge clk);
    compare_next();
  endtask

  task automatic run_table();
    foreach (table_q[i]) apply(table_q[i]);
    table_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    en    = 1'b1;
    #1;
    sb_q.push_back(mk("reset_values", 0, 0, 0, 1, 0, 0, 0, 0, 0));
    compare_next();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    mode     = 1'b0;
    load_val = '0;

    // one-shot from 3
    do_reset();
    table_q.push_back(mk("os_start",   1, 0, 0, 1, 3, 0, 0, 0, 0));
    table_q.push_back(mk("os_cnt3",    0, 0, 0, 1, 3, 3, 0, 1, 0));
    table_q.push_back(mk("os_cnt2",    0, 0, 0, 1, 3, 2, 0, 1, 0));
    table_q.push_back(mk("os_cnt1",    0, 0, 0, 1, 3, 1, 0, 1, 0));
    table_q.push_back(mk("os_bo",      0, 0, 0, 1, 3, 0, 1, 1, 0));
    table_q.push_back(mk("os_done",    0, 0, 0, 1, 3, 0, 0, 0, 1));
    table_q.push_back(mk("os_done2",   0, 0, 0, 1, 3, 0, 0, 0, 1));
    run_table();

    // periodic from 4; load_val change mid-run must not matter
    do_reset();
    apply(mk("per_start", 1, 0, 1, 1, 4, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      apply(mk("per_run", 0, 0, 0, 1, (i >= 7) ? 9 : 4, 4 - (i % 5), (i % 5) == 4, 1, 0));
    end
    apply(mk("per_stop", 0, 1, 0, 1, 9, 4, 0, 1, 0));
    apply(mk("per_idle", 0, 0, 0, 1, 9, 4, 0, 0, 0));

    // gated enable, periodic from 2
    do_reset();
    apply(mk("gate_start", 1, 0, 1, 0, 2, 0, 0, 0, 0));
    for (int j = 0; j < 12; j++) begin
      int c;
      c = 2 - (((j + 1) / 2) % 3);
      apply(mk("gate_run", 0, 0, 1, (j % 2) == 0, 2, c, ((j % 2) == 0) && (c == 0), 1, 0));
    end

    // load 0 periodic: bo on every enabled tick
    do_reset();
    apply(mk("z_per_start", 1, 0, 1, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) apply(mk("z_per_bo", 0, 0, 0, 1, 0, 0, 1, 1, 0));
    apply(mk("z_per_noen", 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // load 0 one-shot: one bo then done
    do_reset();
    table_q.push_back(mk("z_os_start", 1, 0, 0, 1, 0, 0, 0, 0, 0));
    table_q.push_back(mk("z_os_bo",    0, 0, 1, 1, 0, 0, 1, 1, 0));
    table_q.push_back(mk("z_os_done",  0, 0, 1, 1, 0, 0, 0, 0, 1));
    table_q.push_back(mk("z_os_done2", 0, 0, 1, 1, 0, 0, 0, 0, 1));
    run_table();

    // load 255 periodic: period of 256 ticks
    do_reset();
    apply(mk("max_start", 1, 0, 1, 1, 255, 0, 0, 0, 0));
    for (int i = 0; i < 600; i++) begin
      apply(mk("max_run", 0, 0, 0, 1, 0, 255 - (i % 256), (i % 256) == 255, 1, 0));
    end

    // start+stop together, then start on the bo cycle with a new value
    do_reset();
    table_q.push_back(mk("ss_both",    1, 1, 0, 1, 3, 0, 0, 0, 0));
    table_q.push_back(mk("ss_cnt3",    0, 0, 0, 1, 3, 3, 0, 1, 0));
    table_q.push_back(mk("ss_cnt2",    0, 0, 0, 1, 3, 2, 0, 1, 0));
    table_q.push_back(mk("ss_cnt1",    0, 0, 0, 1, 3, 1, 0, 1, 0));
    table_q.push_back(mk("bo_restart", 1, 0, 0, 1, 7, 0, 1, 1, 0));
    table_q.push_back(mk("bo_reload7", 0, 0, 0, 0, 7, 7, 0, 1, 0));
    table_q.push_back(mk("bo_hold7",   0, 0, 0, 0, 7, 7, 0, 1, 0));
    run_table();

    // stop during run at cnt 5
    do_reset();
    table_q.push_back(mk("sp_start", 1, 0, 1, 1, 9, 0, 0, 0, 0));
    table_q.push_back(mk("sp_cnt9",  0, 0, 0, 1, 9, 9, 0, 1, 0));
    table_q.push_back(mk("sp_cnt8",  0, 0, 0, 1, 9, 8, 0, 1, 0));
    table_q.push_back(mk("sp_cnt7",  0, 0, 0, 1, 9, 7, 0, 1, 0));
    table_q.push_back(mk("sp_cnt6",  0, 0, 0, 1, 9, 6, 0, 1, 0));
    table_q.push_back(mk("sp_stop5", 0, 1, 0, 1, 9, 5, 0, 1, 0));
    table_q.push_back(mk("sp_idle5", 0, 0, 0, 1, 9, 5, 0, 0, 0));
    table_q.push_back(mk("sp_hold5", 0, 0, 0, 1, 9, 5, 0, 0, 0));
    run_table();

    // asynchronous reset mid-count
    do_reset();
    apply(mk("ar_start", 1, 0, 1, 1, 8, 0, 0, 0, 0));
    apply(mk("ar_cnt8",  0, 0, 1, 1, 8, 8, 0, 1, 0));
    apply(mk("ar_cnt7",  0, 0, 1, 1, 8, 7, 0, 1, 0));
    apply(mk("ar_cnt6",  0, 0, 1, 1, 8, 6, 0, 1, 0));
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(mk("ar_async", 0, 0, 1, 1, 8, 0, 0, 0, 0));
    compare_next();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) apply(mk("ar_idle", 0, 0, 1, 1, 8, 0, 0, 0, 0));
    apply(mk("ar_restart", 1, 0, 1, 1, 2, 0, 0, 0, 0));
    apply(mk("ar_cnt2",    0, 0, 1, 1, 2, 2, 0, 1, 0));

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d entries left, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
